// File: rtl/d_reg_pipe.sv
// Elastic DEPTH-stage register pipeline with valid/ready handshake, bubble collapsing and synchronous flush; DEPTH cycles of latency at full throughput.
// in_ready is combinational from out_ready through the stage-acceptance chain. Define D_REG_PIPE_CNT_EN to add the registered occupancy port cnt.
module d_reg_pipe #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data
`ifdef D_REG_PIPE_CNT_EN
    ,
    output logic [$clog2(DEPTH+1)-1:0] cnt
`endif
);

    logic [DEPTH-1:0] v_q;
    logic [DEPTH-1:0] v_d;
    logic [DEPTH-1:0] acc;
    logic [DEPTH-1:0] ld;
    logic [WIDTH-1:0] d_q [DEPTH];

    // Acceptance ripples from the output end; a running carry keeps the chain acyclic.
    always_comb begin
        logic carry;
        carry          = !v_q[DEPTH-1] | out_ready;
        acc            = '0;
        acc[DEPTH-1]   = carry;
        for (int i = DEPTH - 2; i >= 0; i--) begin
            carry  = !v_q[i] | carry;
            acc[i] = carry;
        end
    end

    assign in_ready = acc[0] & !flush;

    always_comb begin
        v_d   = v_q;
        ld    = '0;
        ld[0] = acc[0] & in_valid & !flush;
        if (acc[0]) begin
            v_d[0] = in_valid;
        end
        for (int i = 1; i < DEPTH; i++) begin
            ld[i] = acc[i] & v_q[i-1] & !flush;
            if (acc[i]) begin
                v_d[i] = v_q[i-1];
            end
        end
        if (flush) begin
            v_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v_q <= '0;
        end else begin
            v_q <= v_d;
        end
    end

    // Data moves only alongside a valid bit, so bubbles never overwrite a held word.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                d_q[i] <= '0;
            end
        end else begin
            if (ld[0]) begin
                d_q[0] <= in_data;
            end
            for (int i = 1; i < DEPTH; i++) begin
                if (ld[i]) begin
                    d_q[i] <= d_q[i-1];
                end
            end
        end
    end

    assign out_valid = v_q[DEPTH-1];
    assign out_data  = d_q[DEPTH-1];

`ifdef D_REG_PIPE_CNT_EN
    localparam int CW = $clog2(DEPTH + 1);

    logic          push;
    logic          pop;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign push = in_valid & in_ready;
    assign pop  = v_q[DEPTH-1] & out_ready & !flush;

    always_comb begin
        cnt_d = cnt_q;
        if (flush) begin
            cnt_d = '0;
        end else if (push && !pop) begin
            cnt_d = cnt_q + CW'(1);
        end else if (pop && !push) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;
`endif

endmodule

// File: tb/tb_d_reg_pipe.sv
// Directed bench for d_reg_pipe: three instances (DEPTH 3, 2, 4) driven by one linear stimulus sequence.
module tb_d_reg_pipe;

    logic clk;
    logic rst;

    logic       a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [7:0] a_in_data, a_out_data;
    logic       b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [7:0] b_in_data, b_out_data;
    logic       c_flush, c_in_valid, c_in_ready, c_out_valid, c_out_ready;
    logic [7:0] c_in_data, c_out_data;
`ifdef D_REG_PIPE_CNT_EN
    logic [1:0] a_cnt;
    logic [1:0] b_cnt;
    logic [2:0] c_cnt;
`endif

    int n_pass  = 0;
    int n_total = 0;

    d_reg_pipe #(.WIDTH(8), .DEPTH(3)) u_a (
        .clk(clk), .rst(rst), .flush(a_flush),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data)
`ifdef D_REG_PIPE_CNT_EN
        , .cnt(a_cnt)
`endif
    );

    d_reg_pipe #(.WIDTH(8), .DEPTH(2)) u_b (
        .clk(clk), .rst(rst), .flush(b_flush),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data)
`ifdef D_REG_PIPE_CNT_EN
        , .cnt(b_cnt)
`endif
    );

    d_reg_pipe #(.WIDTH(8), .DEPTH(4)) u_c (
        .clk(clk), .rst(rst), .flush(c_flush),
        .in_valid(c_in_valid), .in_ready(c_in_ready), .in_data(c_in_data),
        .out_valid(c_out_valid), .out_ready(c_out_ready), .out_data(c_out_data)
`ifdef D_REG_PIPE_CNT_EN
        , .cnt(c_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b0;
        a_flush = 0; a_in_valid = 0; a_in_data = 0; a_out_ready = 0;
        b_flush = 0; b_in_valid = 0; b_in_data = 0; b_out_ready = 0;
        c_flush = 0; c_in_valid = 0; c_in_data = 0; c_out_ready = 0;
        #3;
        check("reset_out_valid", 32'(b_out_valid), 32'd0);
        check("reset_out_data", 32'(b_out_data), 32'd0);
        check("reset_in_ready", 32'(b_in_ready), 32'd1);
`ifdef D_REG_PIPE_CNT_EN
        check("reset_cnt", 32'(c_cnt), 32'd0);
`endif
        tick();
        rst = 1'b1;

        // DEPTH=3 latency and throughput
        a_out_ready = 1; a_in_valid = 1; a_in_data = 8'h01;
        #1;
        check("lat_in_ready", 32'(a_in_ready), 32'd1);
        tick();
        check("lat_e1_valid", 32'(a_out_valid), 32'd0);
        a_in_data = 8'h02;
        tick();
        check("lat_e2_valid", 32'(a_out_valid), 32'd0);
        a_in_data = 8'h03;
        tick();
        a_in_valid = 0;
        check("lat_e3_valid", 32'(a_out_valid), 32'd1);
        check("lat_e3_data", 32'(a_out_data), 32'h01);
        tick();
        check("thr_data2", 32'(a_out_data), 32'h02);
        tick();
        check("thr_data3", 32'(a_out_data), 32'h03);
        check("thr_valid3", 32'(a_out_valid), 32'd1);
        tick();
        check("thr_drained", 32'(a_out_valid), 32'd0);

        // DEPTH=2 backpressure fill
        b_out_ready = 0; b_in_valid = 1; b_in_data = 8'h0A;
        #1;
        check("bp_rdy_A", 32'(b_in_ready), 32'd1);
        tick();
        b_in_data = 8'h0B;
        #1;
        check("bp_rdy_B", 32'(b_in_ready), 32'd1);
        tick();
        b_in_data = 8'h0C;
        #1;
        check("bp_rdy_C_blocked", 32'(b_in_ready), 32'd0);
        tick();
        check("bp_hold_data", 32'(b_out_data), 32'h0A);
        check("bp_hold_rdy", 32'(b_in_ready), 32'd0);
`ifdef D_REG_PIPE_CNT_EN
        check("bp_cnt_full", 32'(b_cnt), 32'd2);
`endif
        b_out_ready = 1;
        #1;
        check("bp_rdy_comb", 32'(b_in_ready), 32'd1);
        tick();
        b_in_valid = 0;
        check("bp_out_B", 32'(b_out_data), 32'h0B);
        tick();
        check("bp_out_C", 32'(b_out_data), 32'h0C);
        check("bp_out_C_vld", 32'(b_out_valid), 32'd1);
        tick();
        check("bp_drained", 32'(b_out_valid), 32'd0);

        // DEPTH=4 bubble collapse
        c_out_ready = 0; c_in_valid = 1; c_in_data = 8'h05;
        tick();
        c_in_valid = 0;
        tick();
        tick();
        c_in_valid = 1; c_in_data = 8'h06;
        tick();
        c_in_valid = 0;
        tick();
        tick();
        tick();
        check("bub_out_valid", 32'(c_out_valid), 32'd1);
        check("bub_out_data", 32'(c_out_data), 32'h05);
        check("bub_in_ready", 32'(c_in_ready), 32'd1);
`ifdef D_REG_PIPE_CNT_EN
        check("bub_cnt", 32'(c_cnt), 32'd2);
`endif
        c_out_ready = 1;
        tick();
        check("bub_second_data", 32'(c_out_data), 32'h06);
        check("bub_second_vld", 32'(c_out_valid), 32'd1);
        tick();
        check("bub_drained", 32'(c_out_valid), 32'd0);

        // DEPTH=2 flush priority
        b_out_ready = 0; b_in_valid = 1; b_in_data = 8'h11;
        tick();
        b_in_data = 8'h22;
        tick();
        b_flush = 1; b_in_data = 8'h33; b_out_ready = 1;
        #1;
        check("fl_in_ready", 32'(b_in_ready), 32'd0);
        tick();
        b_flush = 0; b_in_valid = 0;
        check("fl_out_valid", 32'(b_out_valid), 32'd0);
        check("fl_data_kept", 32'(b_out_data), 32'h11);
`ifdef D_REG_PIPE_CNT_EN
        check("fl_cnt", 32'(b_cnt), 32'd0);
`endif
        tick();
        tick();
        check("fl_no_accept", 32'(b_out_valid), 32'd0);

        // DEPTH=2 full push/pop
        b_out_ready = 0; b_in_valid = 1; b_in_data = 8'h40;
        tick();
        b_in_data = 8'h41;
        tick();
        b_out_ready = 1;
        for (int k = 0; k < 4; k++) begin
            b_in_data = 8'(8'h42 + k);
            #1;
            check("pp_in_ready", 32'(b_in_ready), 32'd1);
            check("pp_out_data", 32'(b_out_data), 32'h40 + 32'(k));
            tick();
`ifdef D_REG_PIPE_CNT_EN
            check("pp_cnt", 32'(b_cnt), 32'd2);
`endif
        end
        b_in_valid = 0;
        check("pp_tail1", 32'(b_out_data), 32'h44);
        tick();
        check("pp_tail2", 32'(b_out_data), 32'h45);
        tick();
        check("pp_drained", 32'(b_out_valid), 32'd0);

        // Asynchronous reset with two words held
        b_out_ready = 0; b_in_valid = 1; b_in_data = 8'h77;
        tick();
        b_in_data = 8'h88;
        tick();
        b_in_valid = 0;
        check("rs_pre_valid", 32'(b_out_valid), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        check("rs_out_valid", 32'(b_out_valid), 32'd0);
        check("rs_out_data", 32'(b_out_data), 32'd0);
        check("rs_in_ready", 32'(b_in_ready), 32'd1);
`ifdef D_REG_PIPE_CNT_EN
        check("rs_cnt", 32'(b_cnt), 32'd0);
`endif
        tick();
        rst = 1'b1;
        b_out_ready = 1;
        tick();
        check("rs_stays_empty", 32'(b_out_valid), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/d_reg_pipe.md
# d_reg_pipe

Parametrised elastic register pipeline: the next generation of the team's single-stage 32-bit D register. It carries a WIDTH-bit word through DEPTH register stages with a valid/ready handshake, per-stage bubble collapsing, and a synchronous flush. It sits between datapath blocks (ALU operand/result paths) wherever retiming with backpressure is needed.

## Interface
- `WIDTH`, 32: data word width in bits; must be at least 1.
- `DEPTH`, 2: number of register stages; must be at least 1.
- `clk`  in  1  rising-edge clock; the only clock.
- `rst`  in  1  asynchronous, active-low reset. Assertion clears all state immediately; release is sampled on `clk`.
- `flush`  in  1  synchronous clear of all stage valid bits.
- `in_valid`  in  1  upstream word present.
- `in_ready`  out  1  pipeline accepts `in_data` this cycle.
- `in_data`  in  WIDTH  input word.
- `out_valid`  out  1  stage DEPTH-1 holds a valid word.
- `out_ready`  in  1  downstream accepts `out_data` this cycle.
- `out_data`  out  WIDTH  word in stage DEPTH-1.
- `cnt`  out  $clog2(DEPTH+1)  number of occupied stages. Present only when `D_REG_PIPE_CNT_EN` is defined.

## Operation
- State per stage i (0..DEPTH-1): `v[i]` (1 bit) and `d[i]` (WIDTH bits).
- Stage acceptance is combinational:
  - `acc[DEPTH-1] = !v[DEPTH-1] | out_ready`
  - `acc[i] = !v[i] | acc[i+1]` for all other stages.
- `in_ready = acc[0] & !flush`.
- Transfer rules on each clock edge with `flush` = 0:
  - Stage 0: if `acc[0]`, then `v[0] <= in_valid`.
  - Stage i>0: if `acc[i]`, then `v[i] <= v[i-1]`.
  - A stage with `acc` = 0 holds both `v` and `d`.
- Data registers load only when a valid word moves in:
  - Stage 0 loads `in_data` when `acc[0] & in_valid`.
  - Stage i>0 loads `d[i-1]` when `acc[i] & v[i-1]`.
  - Otherwise `d` holds its value; bubbles never overwrite data.
- Bubble collapsing: an empty stage accepts even while downstream stalls, so gaps close under backpressure.
- `out_valid = v[DEPTH-1]`, `out_data = d[DEPTH-1]`.
- Flush: all `v` are cleared to 0 on the edge where `flush` = 1. `d` is unchanged. `in_ready` is 0 during flush, so any word offered that cycle is not accepted. Flush takes priority over all transfers, including a simultaneous output handshake.
- Reset (`rst` = 0): all `v` = 0, all `d` = 0 → `out_valid` = 0, `out_data` = 0, `cnt` = 0. `in_ready` = 1 once `flush` is low. Reset mid-transfer discards all words in flight.
- DEPTH = 1 degenerates to a single registered slot with the same rules.

## Timing
- Latency: a word accepted at edge N into an empty pipeline with `out_ready` held high appears on `out_valid`/`out_data` after edge N+DEPTH-1, i.e. DEPTH cycles from the `in_valid`/`in_ready` handshake to the `out_valid` cycle.
- Throughput: one word per cycle when `out_ready` = 1.
- Full pipeline with `out_ready` = 0: `in_ready` = 0; `out_data` stable until the handshake.
- Full pipeline with `out_ready` = 1 and `in_valid` = 1: push and pop happen in the same cycle; occupancy is unchanged.
- `in_ready` depends combinationally on `out_ready` and `flush`, with no registered ready. The path length is DEPTH.
- Outputs `out_valid`, `out_data` and `cnt` are registered or derived only from registers.

## Configuration
- `D_REG_PIPE_CNT_EN` defined:
  - Port `cnt` exists and is registered.
  - `cnt` increments on accepted input without output, decrements on output without input, and is otherwise unchanged.
  - `cnt` is cleared to 0 by flush and by reset.
  - `cnt` always equals the population count of `v`.
- Not defined: port `cnt` and its logic are absent. All other behaviour is identical.

## Test plan
- Reset: drive `rst` = 0 mid-stream with 2 words held → `out_valid` = 0 and `out_data` = 0 immediately (asynchronous); `cnt` = 0.
- Latency/throughput: DEPTH = 3, `out_ready` = 1, stream 0x1, 0x2, 0x3 on consecutive cycles → outputs 0x1, 0x2, 0x3 on consecutive cycles, first appearing 3 cycles after the first handshake.
- Backpressure/fill: DEPTH = 2, `out_ready` = 0, offer 0xA, 0xB, 0xC → 0xA and 0xB accepted, `in_ready` = 0 while 0xC is offered. Raise `out_ready` → order 0xA, 0xB, 0xC with no loss or duplicates.
- Bubble collapse: DEPTH = 4, send 0x5, idle 2 cycles, send 0x6, hold `out_ready` = 0 → both words reach stages 3 and 2, and `cnt` = 2.
- Flush priority: pipeline full, `flush` = 1 with `in_valid` = 1 and `out_ready` = 1 in the same cycle → next cycle `out_valid` = 0 and `cnt` = 0; the offered word is not accepted (`in_ready` = 0).
- Full-pipeline push/pop: full DEPTH = 2 pipeline, `in_valid` = `out_ready` = 1 for 4 cycles → 4 words out, 4 words in, `cnt` constant at 2.
